// File: rtl/nibble_serial_addsub_pkg.sv
// rtl/nibble_serial_addsub_pkg.sv - shared types and constants for the nibble-serial adder/subtractor
//
// Purpose : FSM state encoding and the slice width used by the top and the CLA slice.
// Ports   : none (package).

package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_addsub_cla4.sv
// rtl/nibble_serial_addsub_cla4.sv - 4-bit carry-lookahead adder slice
//
// Purpose : combinational 4-bit add with lookahead carries, one nibble per use.
// Ports   : a, b   [3:0] in   addends
//           c_in         in   carry in
//           s      [3:0] out  sum
//           c_out        out  carry out of bit 3

module nibble_serial_addsub_cla4
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] s,
    output logic                c_out
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of generate/propagate terms,
    // so no carry depends on the carry of the bit below it.
    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);
    assign c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

endmodule

// File: rtl/nibble_serial_addsub.sv
// rtl/nibble_serial_addsub.sv - multi-cycle WIDTH-bit add/sub, one nibble per clock
//
// Purpose : a +/- b computed LSB nibble first through a single CLA slice, with the
//           carry held in a flop between cycles. Valid/ready on both sides.
// Ports   : clk, rst (sync, active high)
//           in_valid/in_ready, a, b, sub     operand handshake (sub=1: a-b)
//           out_valid/out_ready, result      result handshake, result held until taken
//           c_out                            final carry (sub: 1 = no borrow)
//           overflow                         two's-complement signed overflow

module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   a_q,        a_d;
    logic [WIDTH-1:0]   b_q,        b_d;
    logic               carry_q,    carry_d;
    logic [WIDTH-1:0]   result_q,   result_d;
    logic               c_out_q,    c_out_d;
    logic               ovf_q,      ovf_d;
    logic               a_msb_q,    a_msb_d;
    logic               b_msb_q,    b_msb_d;

    logic [NIBBLE_W-1:0] nib_s;
    logic                nib_c;

    nibble_serial_addsub_cla4 u_cla4 (
        .a     (a_q[NIBBLE_W-1:0]),
        .b     (b_q[NIBBLE_W-1:0]),
        .c_in  (carry_q),
        .s     (nib_s),
        .c_out (nib_c)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // Each sum nibble enters at the top; after NIB shifts the LSB nibble
                // has reached bit 0 and the result is in place.
                result_d = {nib_s, result_q[WIDTH-1:NIBBLE_W]};
                a_d      = a_q >> NIBBLE_W;
                b_d      = b_q >> NIBBLE_W;
                carry_d  = nib_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    c_out_d = nib_c;
                    // Overflow: both addends share a sign and the sum's sign differs.
                    ovf_d   = (a_msb_q == b_msb_q) && (nib_s[NIBBLE_W-1] != a_msb_q);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// tb/tb_nibble_serial_addsub.sv - scoreboard bench for nibble_serial_addsub

module tb_nibble_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        c_out;
    logic        overflow;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .c_out     (c_out),
        .overflow  (overflow)
    );

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t e;
        logic [32:0] t;
        if (!s) begin
            t   = {1'b0, x} + {1'b0, y};
            e.r = t[31:0];
            e.c = t[32];
            e.v = (x[31] == y[31]) && (e.r[31] != x[31]);
        end else begin
            e.r = x - y;
            e.c = (x >= y);
            e.v = (x[31] != y[31]) && (e.r[31] != x[31]);
        end
        return e;
    endfunction

    // Returns at the negedge after the accepting edge, with in_valid dropped.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         input bit push, input exp_t e);
        int n;
        @(negedge clk);
        a = ia; b = ib; sub = is; in_valid = 1'b1;
        n = 0;
        while (!in_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        if (push) q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Monitor: choose out_ready for the coming edge, then score any handshake it completes.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result",   result,          e.r);
                    chk("c_out",    32'(c_out),      32'(e.c));
                    chk("overflow", 32'(overflow),   32'(e.v));
                end
            end
        end
    end

    logic [31:0] dir_a [8];
    logic [31:0] dir_b [8];
    logic        dir_s [8];
    logic [31:0] dir_r [8];
    logic        dir_c [8];
    logic        dir_v [8];

    initial begin
        exp_t e;
        int   lat;
        int   n;
        int   hi;

        dir_a = '{32'h0000000F, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000000,
                  32'h12345678, 32'h80000000, 32'h80000000, 32'h12345678};
        dir_b = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                  32'h12345678, 32'h00000001, 32'h80000000, 32'h9ABCDEF0};
        dir_s = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dir_r = '{32'h00000010, 32'h00000000, 32'h80000000, 32'hFFFFFFFF,
                  32'h00000000, 32'h7FFFFFFF, 32'h00000000, 32'hACF13568};
        dir_c = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        dir_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    result,         32'd0);
        chk("rst_c_out",     32'(c_out),     32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);

        // Carry across a nibble boundary, with latency measured from the accepting edge.
        e.r = 32'h00000010; e.c = 1'b0; e.v = 1'b0;
        issue(32'h0000000F, 32'h00000001, 1'b0, 1, e);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd8);
        drain();

        // Directed boundary vectors.
        for (int i = 0; i < 8; i++) begin
            e.r = dir_r[i]; e.c = dir_c[i]; e.v = dir_v[i];
            issue(dir_a[i], dir_b[i], dir_s[i], 1, e);
        end
        drain();

        // Reset in the middle of a computation: no result may appear.
        issue(32'h11111111, 32'h22222222, 1'b0, 0, e);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result",    result,         32'd0);
        hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        chk("midrst_no_out_valid", 32'(hi), 32'd0);

        // Back-pressure in DONE; new operands offered meanwhile must be ignored.
        rdy_mode = 2;
        e.r = 32'hACF13568; e.c = 1'b0; e.v = 1'b0;
        issue(32'h12345678, 32'h9ABCDEF0, 1'b0, 1, e);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", 32'(out_valid), 32'd1);
        a = 32'hFFFFFFFF; b = 32'h00000001; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_result",    result,         32'hACF13568);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_release", 32'(out_valid), 32'd0);
        chk("stall_idle_in_ready", 32'(in_ready), 32'd1);
        drain();

        // Random operands with random consumer back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, 1, model(ra, rb, rs));
        end
        rdy_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
